// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit for the EX stage.
// Operands are captured on an accepted start; the {hi,lo} result and the
// divide-by-zero flag are loaded when the FSM enters FIN and then held until
// the next completed operation.
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | waiting for start; result/div_by_zero hold their last values
// MUL   | product settling, MUL_STAGES-1 cycles counted down
// DIV   | restoring radix-2 divide, one quotient bit per cycle, WIDTH cycles
// FIN   | done pulse; result/div_by_zero were loaded on entry to this state

module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    localparam int CNT_MAX = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_STAGES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               load_res;
    logic [2*WIDTH-1:0] result_d;
    logic               dbz_d;

    logic               op_sgn;
    logic               accept;

    logic               mul_sgn;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;

    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dvsr;
    logic               neg_q;
    logic               neg_r;

    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic               div_bit;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_fin;
    logic [WIDTH-1:0]   rem_fin;

    // Full 2*WIDTH product; sign-extending both operands and truncating the
    // product to 2*WIDTH bits gives the correct two's-complement result.
    function automatic logic [2*WIDTH-1:0] mul_full(input logic             sgn,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] ea;
        logic [2*WIDTH-1:0] eb;
        ea = {{WIDTH{sgn & a[WIDTH-1]}}, a};
        eb = {{WIDTH{sgn & b[WIDTH-1]}}, b};
        return ea * eb;
    endfunction

    // Magnitude of a (possibly signed) operand; -2^(W-1) maps to 2^(W-1),
    // which still fits as an unsigned WIDTH-bit value.
    function automatic logic [WIDTH-1:0] magnitude(input logic             sgn,
                                                   input logic [WIDTH-1:0] v);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    assign op_sgn = ~op[0];
    assign accept = (state == IDLE) && start && !flush;

    // One restoring-division step plus the sign fix-up used on the last step.
    // The partial remainder always stays below the divisor, so WIDTH bits hold it.
    always_comb begin
        div_shift = {rem, quo[WIDTH-1]};
        div_trial = div_shift - {1'b0, dvsr};
        div_bit   = ~div_trial[WIDTH];
        rem_step  = div_bit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quo_step  = {quo[WIDTH-2:0], div_bit};
        quo_fin   = neg_q ? -quo_step : quo_step;
        rem_fin   = neg_r ? -rem_step : rem_step;
    end

    // State and down-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, counter, result-load and handshake outputs.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_res  = 1'b0;
        result_d  = result;
        dbz_d     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                if (start && !flush) begin
                    if (!op[1]) begin
                        if (MUL_STAGES == 1) begin
                            state_nxt = FIN;
                            load_res  = 1'b1;
                            result_d  = mul_full(op_sgn, src_a, src_b);
                        end else begin
                            state_nxt = MUL;
                            cnt_nxt   = CNT_MUL;
                        end
                    end else if (src_b == '0) begin
                        state_nxt = FIN;
                        load_res  = 1'b1;
                        result_d  = {src_a, {WIDTH{1'b1}}};
                        dbz_d     = 1'b1;
                    end else begin
                        state_nxt = DIV;
                        cnt_nxt   = CNT_DIV;
                    end
                end
            end

            MUL: begin
                busy = 1'b1;
                if (cnt == CNT_ONE) begin
                    state_nxt = FIN;
                    load_res  = 1'b1;
                    result_d  = mul_full(mul_sgn, mul_a, mul_b);
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end

            DIV: begin
                busy    = 1'b1;
                cnt_nxt = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    state_nxt = FIN;
                    load_res  = 1'b1;
                    result_d  = {rem_fin, quo_fin};
                end
            end

            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // An abort drops whatever is in flight and never publishes a result.
        if (flush) begin
            state_nxt = IDLE;
            load_res  = 1'b0;
        end
    end

    // Operand capture on accept; divider iteration while in DIV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_sgn <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
            quo     <= '0;
            rem     <= '0;
            dvsr    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (accept) begin
            mul_sgn <= op_sgn;
            mul_a   <= src_a;
            mul_b   <= src_b;
            quo     <= magnitude(op_sgn, src_a);
            rem     <= '0;
            dvsr    <= magnitude(op_sgn, src_b);
            neg_q   <= op_sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_r   <= op_sgn & src_a[WIDTH-1];
        end else if (state == DIV) begin
            quo <= quo_step;
            rem <= rem_step;
        end
    end

    // Result and flag registers, loaded only on the transition into FIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result      <= '0;
            div_by_zero <= 1'b0;
        end else if (load_res) begin
            result      <= result_d;
            div_by_zero <= dbz_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit (WIDTH=32, MUL_STAGES=2): directed operations
// with hand-computed results, plus a latency-based reference model checked
// against the DUT outputs on every falling clock edge.

module tb_muldiv_unit;

    localparam int WIDTH      = 32;
    localparam int MUL_STAGES = 2;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(
        .WIDTH      (WIDTH),
        .MUL_STAGES (MUL_STAGES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what an accepted op must produce and how many cycles
    // after the start cycle its done pulse appears.
    task automatic model_op(input  logic [1:0]  o,
                            input  logic [31:0] a,
                            input  logic [31:0] b,
                            output logic [63:0] res,
                            output logic        dbz,
                            output int          lat);
        int          sa;
        int          sb;
        logic [31:0] q;
        logic [31:0] r;
        sa  = a;
        sb  = b;
        dbz = 1'b0;
        res = '0;
        lat = 0;
        case (o)
            2'b00: begin
                res = longint'(sa) * longint'(sb);
                lat = MUL_STAGES;
            end
            2'b01: begin
                res = {32'h0, a} * {32'h0, b};
                lat = MUL_STAGES;
            end
            default: begin
                if (b == 32'h0) begin
                    res = {a, 32'hFFFFFFFF};
                    dbz = 1'b1;
                    lat = 1;
                end else begin
                    lat = WIDTH + 1;
                    if (o == 2'b11) begin
                        q = a / b;
                        r = a % b;
                    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                        q = 32'h80000000;
                        r = 32'h0;
                    end else begin
                        q = sa / sb;
                        r = sa % sb;
                    end
                    res = {r, q};
                end
            end
        endcase
    endtask

    logic        m_busy     = 1'b0;
    logic        m_done     = 1'b0;
    logic        m_dbz      = 1'b0;
    logic [63:0] m_result   = '0;
    logic [63:0] m_pend_res = '0;
    logic        m_pend_dbz = 1'b0;
    bit          m_active   = 1'b0;
    bit          m_was_done = 1'b0;
    int          m_left     = 0;
    int          m_lat      = 0;

    // Advance the model one clock: count down an in-flight op, honour flush,
    // accept a new op only when nothing is in flight and no done is showing.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_left   = 0;
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_dbz    = 1'b0;
            m_result = '0;
        end else begin
            m_was_done = m_done;
            m_done     = 1'b0;
            if (m_active) begin
                if (flush) begin
                    m_active = 1'b0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                        m_result = m_pend_res;
                        m_dbz    = m_pend_dbz;
                    end
                end
            end else if (!m_was_done && start && !flush) begin
                model_op(op, src_a, src_b, m_pend_res, m_pend_dbz, m_lat);
                if (m_lat == 1) begin
                    m_done   = 1'b1;
                    m_result = m_pend_res;
                    m_dbz    = m_pend_dbz;
                end else begin
                    m_active = 1'b1;
                    m_left   = m_lat - 1;
                end
            end
            m_busy = m_active;
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        chk("cmp_busy", busy, m_busy);
        chk("cmp_done", done, m_done);
        chk("cmp_result", result, m_result);
        chk("cmp_dbz", div_by_zero, m_dbz);
    end

    // Issue one op in the current cycle and check its hand-computed outcome.
    task automatic run_op(input string       nm,
                          input logic [1:0]  o,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input int          lat,
                          input logic [63:0] res,
                          input logic        dbz);
        int n;
        bit seen;
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        n     = 1;
        seen  = 1'b0;
        while (!seen && n <= 200) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk({nm, "_latency"}, seen ? n : -1, lat);
        chk({nm, "_result"}, result, res);
        chk({nm, "_dbz"}, div_by_zero, dbz);
        chk({nm, "_busy_at_done"}, busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    int ndone;

    initial begin
        rst   = 1'b0;
        flush = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        src_a = '0;
        src_b = '0;
        #2 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_result", result, 64'h0);
        chk("reset_dbz", div_by_zero, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("mult_neg",   2'b00, 32'hFFFFFFFD, 32'd5,        2,  64'hFFFFFFFF_FFFFFFF1, 1'b0);
        run_op("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 2,  64'hFFFFFFFE_00000001, 1'b0);
        run_op("mult_min",   2'b00, 32'h80000000, 32'h80000000, 2,  64'h40000000_00000000, 1'b0);
        run_op("divu_100_7", 2'b11, 32'd100,      32'd7,        33, 64'h00000002_0000000E, 1'b0);
        run_op("div_m7_2",   2'b10, 32'hFFFFFFF9, 32'd2,        33, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
        run_op("div_7_m2",   2'b10, 32'd7,        32'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD, 1'b0);
        run_op("div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000, 1'b0);
        run_op("divu_small", 2'b11, 32'd5,        32'd7,        33, 64'h00000005_00000000, 1'b0);
        run_op("div_zero",   2'b10, 32'h00001234, 32'h0,        1,  64'h00001234_FFFFFFFF, 1'b1);

        // Flush a divide at cycle 10, then start a multiply at cycle 11.
        op    = 2'b11;
        src_a = 32'd100;
        src_b = 32'd7;
        start = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        chk("flush_done", done, 1'b0);
        chk("flush_result_held", result, 64'h00001234_FFFFFFFF);
        chk("flush_dbz_held", div_by_zero, 1'b1);
        run_op("mult_after_flush", 2'b00, 32'd6, 32'hFFFFFFF9, 2, 64'hFFFFFFFF_FFFFFFD6, 1'b0);

        // Flush and start together: the op must not be accepted.
        op    = 2'b00;
        src_a = 32'd3;
        src_b = 32'd3;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", busy, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end

        // A start while busy is ignored: exactly one done in the window.
        op    = 2'b11;
        src_a = 32'd100;
        src_b = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        op    = 2'b00;
        src_a = 32'd9;
        src_b = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("busy_start_done_count", ndone, 1);
        chk("busy_start_result", result, 64'h00000002_0000000E);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a divide.
        op    = 2'b11;
        src_a = 32'd1000;
        src_b = 32'd3;
        start = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        #1 rst = 1'b1;
        #1;
        chk("midop_reset_busy", busy, 1'b0);
        chk("midop_reset_done", done, 1'b0);
        chk("midop_reset_result", result, 64'h0);
        chk("midop_reset_dbz", div_by_zero, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("divu_zero", 2'b11, 32'h0000ABCD, 32'h0, 1, 64'h0000ABCD_FFFFFFFF, 1'b1);
        run_op("multu_tail", 2'b01, 32'h00010000, 32'h00010000, 2, 64'h00000001_00000000, 1'b0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
